// File: rtl/niosii_usb_cpu_div_cell_if.sv
// ============================================================================
// niosii_usb_cpu_div_cell_if : operand/result bundle between E stage and divider
// Revision 1.0
// ============================================================================
`default_nettype none

interface niosii_usb_cpu_div_cell_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] E_src1;
   logic [WIDTH-1:0] E_src2;
   logic             E_div_signed;
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] M_div_quot;
   logic [WIDTH-1:0] M_div_rem;

   modport master (
      output E_src1, E_src2, E_div_signed, start, abort,
      input  busy, done, M_div_quot, M_div_rem
   );

   modport slave (
      input  E_src1, E_src2, E_div_signed, start, abort,
      output busy, done, M_div_quot, M_div_rem
   );
endinterface

`default_nettype wire

// File: rtl/niosii_usb_cpu_div_cell.sv
// ============================================================================
// niosii_usb_cpu_div_cell : iterative restoring radix-2 signed/unsigned divider
// Option macro: NIOSII_DIV_CELL_EARLY_OUT_EN (skip iterations when |a| < |b|)
// Revision 1.0
// ============================================================================
`default_nettype none

module niosii_usb_cpu_div_cell #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   niosii_usb_cpu_div_cell_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] orig_a;
   logic [WIDTH-1:0] orig_b;
   logic             op_signed;
   logic             sign_q;
   logic             sign_r;
   logic             dz;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] res_quot;
   logic [WIDTH-1:0] res_rem;

   logic             accept;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             early;
   logic             last_iter;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   assign accept    = bus.start && !bus.abort && (state == IDLE || state == DONE);
   assign abs_a     = (op_signed && orig_a[WIDTH-1]) ? -orig_a : orig_a;
   assign abs_b     = (op_signed && orig_b[WIDTH-1]) ? -orig_b : orig_b;
   assign last_iter = (cnt == CNT_W'(WIDTH-1));
   assign rem_sh    = {rem, quo[WIDTH-1]};
   assign trial     = rem_sh - {1'b0, dvs};

`ifdef NIOSII_DIV_CELL_EARLY_OUT_EN
   assign early = (abs_b == '0) || (abs_a < abs_b);
`else
   assign early = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = PREP;
         PREP: begin
            if (bus.abort)  state_nxt = IDLE;
            else if (early) state_nxt = FIX;
            else            state_nxt = ITER;
         end
         ITER: begin
            if (bus.abort)      state_nxt = IDLE;
            else if (last_iter) state_nxt = FIX;
         end
         FIX:  state_nxt = bus.abort ? IDLE : DONE;
         DONE: state_nxt = accept ? PREP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         orig_a    <= '0;
         orig_b    <= '0;
         op_signed <= 1'b0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         dz        <= 1'b0;
         quo       <= '0;
         rem       <= '0;
         dvs       <= '0;
         cnt       <= '0;
         res_quot  <= '0;
         res_rem   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  orig_a    <= bus.E_src1;
                  orig_b    <= bus.E_src2;
                  op_signed <= bus.E_div_signed;
                  sign_q    <= bus.E_div_signed & (bus.E_src1[WIDTH-1] ^ bus.E_src2[WIDTH-1]);
                  sign_r    <= bus.E_div_signed & bus.E_src1[WIDTH-1];
               end
            end
            PREP: begin
               // Early-out leaves |a| as the remainder so FIX restores its sign
               quo <= early ? '0 : abs_a;
               rem <= early ? abs_a : '0;
               dvs <= abs_b;
               dz  <= (abs_b == '0);
               cnt <= '0;
            end
            ITER: begin
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (!bus.abort) begin
                  if (dz) begin
                     res_quot <= '1;
                     res_rem  <= orig_a;
                  end else begin
                     res_quot <= sign_q ? -quo : quo;
                     res_rem  <= sign_r ? -rem : rem;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state == PREP) || (state == ITER) || (state == FIX);
   assign bus.done       = (state == DONE);
   assign bus.M_div_quot = res_quot;
   assign bus.M_div_rem  = res_rem;

endmodule

`default_nettype wire

// File: tb/tb_niosii_usb_cpu_div_cell.sv
// ============================================================================
// tb_niosii_usb_cpu_div_cell : directed vectors with queue-based result scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_niosii_usb_cpu_div_cell;

   localparam int LAT_FULL = 35;
`ifdef NIOSII_DIV_CELL_EARLY_OUT_EN
   localparam int LAT_SHORT = 3;
`else
   localparam int LAT_SHORT = 35;
`endif

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   niosii_usb_cpu_div_cell_if #(.WIDTH(32)) bus ();

   niosii_usb_cpu_div_cell #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quot", bus.M_div_quot, e.q);
            chk("rem", bus.M_div_rem, e.r);
            chk("done_cycle", cyc, e.c);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step();
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit push, input logic [31:0] eq, input logic [31:0] er,
                        input int lat);
      bus.E_src1       = a;
      bus.E_src2       = b;
      bus.E_div_signed = s;
      bus.start        = 1'b1;
      if (push) sb.push_back('{q: eq, r: er, c: cyc + lat});
      step();
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         step();
         k++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
         sb.delete();
      end
      step();
   endtask

   initial begin
      int t;
      bus.E_src1       = '0;
      bus.E_src2       = '0;
      bus.E_div_signed = 1'b0;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      reset            = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_quot", bus.M_div_quot, 32'd0);
      chk("rst_rem", bus.M_div_rem, 32'd0);
      repeat (50) step();

      // Unsigned 100/7 with busy window
      t = cyc;
      issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, LAT_FULL);
      chk("busy_T+1", {31'd0, bus.busy}, 32'd1);
      wait_cyc(t + 34);
      chk("busy_T+34", {31'd0, bus.busy}, 32'd1);
      wait_cyc(t + 35);
      chk("busy_T+35", {31'd0, bus.busy}, 32'd0);
      drain();

      issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, LAT_FULL);
      drain();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0, LAT_FULL);
      drain();
      issue(32'd1234, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1234, LAT_SHORT);
      drain();
      issue(32'd1234, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1234, LAT_SHORT);
      drain();
      issue(32'd5, 32'd9, 1'b0, 1'b1, 32'd0, 32'd5, LAT_SHORT);
      drain();
      issue(32'hFFFF_FFFB, 32'd9, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFB, LAT_SHORT);
      drain();

      // Abort mid-iteration: no done, previous results held
      t = cyc;
      issue(32'd1000, 32'd10, 1'b0, 1'b0, 32'd0, 32'd0, LAT_FULL);
      wait_cyc(t + 10);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_quot", bus.M_div_quot, 32'd0);
      chk("abort_rem", bus.M_div_rem, 32'hFFFF_FFFB);
      repeat (40) step();

      // Abort beats start in IDLE
      bus.abort = 1'b1;
      issue(32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, LAT_FULL);
      bus.abort = 1'b0;
      chk("abort_start_busy", {31'd0, bus.busy}, 32'd0);
      repeat (40) step();

      // Ignored start while busy, then back-to-back start in DONE
      t = cyc;
      issue(32'd200, 32'd3, 1'b0, 1'b1, 32'd66, 32'd2, LAT_FULL);
      wait_cyc(t + 5);
      issue(32'd9, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, LAT_FULL);
      wait_cyc(t + 35);
      issue(32'd77, 32'd5, 1'b0, 1'b1, 32'd15, 32'd2, LAT_FULL);
      drain();

      // Reset mid-operation
      t = cyc;
      issue(32'd300, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0, LAT_FULL);
      wait_cyc(t + 20);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
      chk("mid_rst_quot", bus.M_div_quot, 32'd0);
      chk("mid_rst_rem", bus.M_div_rem, 32'd0);
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
